osd_cdm_core_responder: RTL and testbench

- Core-side responder for the CDM debug access interface (strobe/write/adr/data_in -> ack/data_out, plus stall/breakpoint).
- Sits between the CDM-ADS debug module and one CPU core.
- Serves a small local debug register file and forwards all other accesses to the core's SPR port.
- Generates the core stall and the breakpoint indication; supports trap breakpoints and single-step.

---
 rtl/osd_cdm_core_responder_pkg.sv | 27 ++
 rtl/osd_cdm_core_responder_if.sv | 24 ++
 rtl/osd_cdm_core_responder_stall_ctrl.sv | 54 +++++
 rtl/osd_cdm_core_responder.sv | 158 +++++++++++++++
 tb/tb_osd_cdm_core_responder.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_cdm_core_responder_pkg.sv
// rtl/osd_cdm_core_responder_pkg.sv - shared constants and types for the CDM core responder
// Contents: local register map, DCR/DSR bit positions, access FSM state encoding.
package osd_cdm_pkg;

    // Local register map; everything at or above CDM_SPR_BASE belongs to the core.
    localparam logic [14:0] CDM_DCR      = 15'h0000;
    localparam logic [14:0] CDM_DSR      = 15'h0001;
    localparam logic [14:0] CDM_ID       = 15'h0002;
    localparam logic [14:0] CDM_SPR_BASE = 15'h1000;

    localparam int DCR_STEP_EN = 0;
    localparam int DSR_BP      = 0;
    localparam int DSR_STEP    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCAL,
        ST_SPR,
        ST_ACK,
        ST_RELEASE
    } cdm_state_t;

    function automatic logic is_local(input logic [14:0] adr);
        return adr < CDM_SPR_BASE;
    endfunction

endpackage

// File: rtl/osd_cdm_core_responder_if.sv
// rtl/osd_cdm_core_responder_if.sv - CDM debug access bus between debug module and core responder
// Signals: du_strobe/du_write/du_adr/du_data_in driven by the debug module (master),
//          du_ack/du_data_out driven by the core responder (slave).
interface osd_cdm_core_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  du_strobe;
    logic                  du_write;
    logic [ADDR_WIDTH-1:0] du_adr;
    logic [DATA_WIDTH-1:0] du_data_in;
    logic                  du_ack;
    logic [DATA_WIDTH-1:0] du_data_out;

    modport master (
        output du_strobe, du_write, du_adr, du_data_in,
        input  du_ack, du_data_out
    );

    modport slave (
        input  du_strobe, du_write, du_adr, du_data_in,
        output du_ack, du_data_out
    );
endinterface

// File: rtl/osd_cdm_core_responder_stall_ctrl.sv
// rtl/osd_cdm_core_responder_stall_ctrl.sv - breakpoint hold, debug status register and single-step
// Ports: clk/rst; du_stall (debug stall request); core_trap/core_retire (core event pulses);
//        step_en (DCR.STEP_EN); dsr_wr/dsr_wdata (write-one-to-clear DSR access);
//        bp_hold (core held by trap or step); dsr (status bits {STEP, BP}).
module osd_cdm_stall_ctrl
    import osd_cdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       du_stall,
    input  logic       core_trap,
    input  logic       core_retire,
    input  logic       step_en,
    input  logic       dsr_wr,
    input  logic [1:0] dsr_wdata,
    output logic       bp_hold,
    output logic [1:0] dsr
);

    logic       du_stall_q;
    logic       resume;
    logic       set_bp;
    logic       set_step;
    logic [1:0] dsr_after_wr;
    logic       dsr_wr_clears;

    // Resume is the debugger releasing its stall request.
    assign resume   = du_stall_q & ~du_stall;
    assign set_bp   = core_trap;
    // A step only counts when the core was actually running on its own.
    assign set_step = core_retire & step_en & ~bp_hold & ~du_stall;

    assign dsr_after_wr  = dsr_wr ? (dsr & ~dsr_wdata) : dsr;
    assign dsr_wr_clears = dsr_wr && (dsr_after_wr == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            du_stall_q <= 1'b0;
            dsr        <= 2'b00;
            bp_hold    <= 1'b0;
        end else begin
            du_stall_q     <= du_stall;
            // New events are ORed in after the clear so a set always wins.
            dsr[DSR_BP]   <= dsr_after_wr[DSR_BP] | set_bp;
            dsr[DSR_STEP] <= dsr_after_wr[DSR_STEP] | set_step;
            if (set_bp || set_step) begin
                bp_hold <= 1'b1;
            end else if (resume || dsr_wr_clears) begin
                bp_hold <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/osd_cdm_core_responder.sv
// rtl/osd_cdm_core_responder.sv - core-side CDM debug responder: local registers plus SPR forwarding
// Ports: clk/rst; du_stall (debug stall request); du (CDM access bus, slave side);
//        du_breakpoint/core_stall (halt indications); core_trap/core_retire (core events);
//        spr_req/spr_we/spr_addr/spr_wdata/spr_rdata/spr_ack (core SPR access port).
module osd_cdm_core_responder
    import osd_cdm_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    SPR_TIMEOUT = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   du_stall,
    osd_cdm_core_responder_if.slave du,
    output logic                   du_breakpoint,
    output logic                   core_stall,
    input  logic                   core_trap,
    input  logic                   core_retire,
    output logic                   spr_req,
    output logic                   spr_we,
    output logic [14:0]            spr_addr,
    output logic [DATA_WIDTH-1:0]  spr_wdata,
    input  logic [DATA_WIDTH-1:0]  spr_rdata,
    input  logic                   spr_ack
);

    localparam int         CNT_W = $clog2(SPR_TIMEOUT + 1);
    localparam logic [7:0] ID_DW = 8'(DATA_WIDTH);
    localparam logic [7:0] ID_AW = 8'(ADDR_WIDTH);

    cdm_state_t            state;
    cdm_state_t            state_nxt;
    logic [14:0]           adr_in;
    logic [14:0]           adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] local_rdata;
    logic [CNT_W-1:0]      cnt;
    logic                  timeout;
    logic                  step_en;
    logic                  dsr_wr;
    logic                  bp_hold;
    logic [1:0]            dsr;

    // The top address bit carries no meaning on this bus.
    logic [ADDR_WIDTH-16:0] unused_adr_hi;
    assign unused_adr_hi = du.du_adr[ADDR_WIDTH-1:15];
    assign adr_in        = du.du_adr[14:0];

    assign timeout       = (cnt == CNT_W'(SPR_TIMEOUT - 1));
    assign core_stall    = du_stall | bp_hold;
    assign du_breakpoint = bp_hold;
    assign spr_addr      = adr_q;
    assign spr_wdata     = wdata_q;

    osd_cdm_stall_ctrl u_stall_ctrl (
        .clk         (clk),
        .rst         (rst),
        .du_stall    (du_stall),
        .core_trap   (core_trap),
        .core_retire (core_retire),
        .step_en     (step_en),
        .dsr_wr      (dsr_wr),
        .dsr_wdata   (wdata_q[1:0]),
        .bp_hold     (bp_hold),
        .dsr         (dsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // SPR traffic is held back until the core pipeline is frozen.
                if (du.du_strobe) begin
                    if (is_local(adr_in)) begin
                        state_nxt = ST_LOCAL;
                    end else if (core_stall) begin
                        state_nxt = ST_SPR;
                    end
                end
            end
            ST_LOCAL:   state_nxt = ST_ACK;
            ST_SPR:     if (spr_ack || timeout) state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_RELEASE;
            ST_RELEASE: if (!du.du_strobe) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        du.du_ack      = (state == ST_ACK);
        du.du_data_out = (state == ST_ACK) ? rdata_q : '0;
        spr_req        = (state == ST_SPR);
        spr_we         = (state == ST_SPR) && we_q;
        dsr_wr         = (state == ST_LOCAL) && we_q && (adr_q == CDM_DSR);
    end

    always_comb begin
        local_rdata = '0;
        case (adr_q)
            CDM_DCR: local_rdata[DCR_STEP_EN] = step_en;
            CDM_DSR: local_rdata[1:0]         = dsr;
            CDM_ID:  local_rdata              = DATA_WIDTH'({16'h0, ID_DW, ID_AW});
            default: local_rdata              = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
            step_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (state_nxt != ST_IDLE) begin
                        adr_q   <= adr_in;
                        we_q    <= du.du_write;
                        wdata_q <= du.du_data_in;
                        cnt     <= '0;
                    end
                end
                ST_LOCAL: begin
                    rdata_q <= we_q ? '0 : local_rdata;
                    if (we_q && (adr_q == CDM_DCR)) begin
                        step_en <= wdata_q[DCR_STEP_EN];
                    end
                end
                ST_SPR: begin
                    if (spr_ack) begin
                        rdata_q <= we_q ? '0 : spr_rdata;
                    end else if (timeout) begin
                        rdata_q <= we_q ? '0 : ERR_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_cdm_core_responder.sv
// tb/tb_osd_cdm_core_responder.sv - self-checking bench for the CDM core responder
module tb_osd_cdm_core_responder;

    logic        clk;
    logic        rst;
    logic        du_stall;
    logic        du_breakpoint;
    logic        core_stall;
    logic        core_trap;
    logic        core_retire;
    logic        spr_req;
    logic        spr_we;
    logic [14:0] spr_addr;
    logic [31:0] spr_wdata;
    logic [31:0] spr_rdata;
    logic        spr_ack;

    osd_cdm_core_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) du_if ();

    osd_cdm_core_responder #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (16),
        .SPR_TIMEOUT (64),
        .ERR_DATA    (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .du_stall      (du_stall),
        .du            (du_if.slave),
        .du_breakpoint (du_breakpoint),
        .core_stall    (core_stall),
        .core_trap     (core_trap),
        .core_retire   (core_retire),
        .spr_req       (spr_req),
        .spr_we        (spr_we),
        .spr_addr      (spr_addr),
        .spr_wdata     (spr_wdata),
        .spr_rdata     (spr_rdata),
        .spr_ack       (spr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    logic [31:0] exp_q[$];

    // SPR port model state
    int          spr_delay = 0;
    logic [31:0] spr_data  = '0;
    int          spr_cnt   = 0;
    int          spr_cnt_last = 0;
    bit          spr_done  = 0;
    bit          spr_kick  = 0;
    logic [14:0] seen_addr = '0;
    logic        seen_we   = 1'b0;
    logic [31:0] seen_wdata = '0;

    typedef struct {
        bit          write;
        logic [15:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every du_ack pops one expected read value.
    always @(negedge clk) begin
        if (!rst && du_if.du_ack) begin
            if (exp_q.size() == 0) begin
                asserts++;
                fails++;
                $display("FAIL unexpected_ack: got du_ack=1 data %h expected no ack at %0t",
                         du_if.du_data_out, $time);
            end else begin
                chk("rdata", du_if.du_data_out, exp_q.pop_front());
            end
        end
    end

    // SPR responder: acks spr_delay cycles after seeing spr_req (0 = never).
    initial begin
        spr_ack   = 1'b0;
        spr_rdata = '0;
        forever begin
            @(posedge clk); #1;
            spr_ack = 1'b0;
            if (spr_kick) begin
                spr_ack   = 1'b1;
                spr_rdata = 32'hFFFF0000;
                spr_kick  = 0;
            end else if (rst || !spr_req) begin
                spr_cnt  = 0;
                spr_done = 0;
            end else if (!spr_done) begin
                spr_cnt++;
                spr_cnt_last = spr_cnt;
                if (spr_delay > 0 && spr_cnt == spr_delay) begin
                    spr_ack    = 1'b1;
                    spr_rdata  = spr_data;
                    spr_done   = 1;
                    seen_addr  = spr_addr;
                    seen_we    = spr_we;
                    seen_wdata = spr_wdata;
                end
            end
        end
    end

    task automatic start_access(input bit w, input logic [15:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        @(posedge clk); #1;
        exp_q.push_back(e);
        du_if.du_strobe  = 1'b1;
        du_if.du_write   = w;
        du_if.du_adr     = a;
        du_if.du_data_in = d;
    endtask

    task automatic finish_access(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (du_if.du_ack) break;
        end
        if (!du_if.du_ack) begin
            asserts++;
            fails++;
            $display("FAIL ack_wait: got no du_ack after %0d cycles expected an ack", lat);
            exp_q.delete();
        end
        // Keep strobe high past the ack; a second ack is caught by the scoreboard.
        repeat (2) @(posedge clk);
        #1;
        du_if.du_strobe = 1'b0;
        du_if.du_write  = 1'b0;
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [31:0] d,
                          input logic [31:0] e, output int lat);
        start_access(w, a, d, e);
        finish_access(lat);
    endtask

    task automatic pulse(input bit trap, input bit retire);
        @(posedge clk); #1;
        core_trap   = trap;
        core_retire = retire;
        @(posedge clk); #1;
        core_trap   = 1'b0;
        core_retire = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0]  = '{1'b1, 16'h0000, 32'h00000001, 32'h00000000};
        vecs[1]  = '{1'b0, 16'h0000, 32'h00000000, 32'h00000001};
        vecs[2]  = '{1'b0, 16'h0002, 32'h00000000, 32'h00002010};
        vecs[3]  = '{1'b0, 16'h0001, 32'h00000000, 32'h00000000};
        vecs[4]  = '{1'b1, 16'h0005, 32'hFFFFFFFF, 32'h00000000};
        vecs[5]  = '{1'b0, 16'h0005, 32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b0, 16'h0FFF, 32'h00000000, 32'h00000000};
        vecs[7]  = '{1'b1, 16'h8000, 32'h00000000, 32'h00000000};
        vecs[8]  = '{1'b0, 16'h0000, 32'h00000000, 32'h00000000};
        vecs[9]  = '{1'b1, 16'h0000, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{1'b0, 16'h8000, 32'h00000000, 32'h00000001};
        vecs[11] = '{1'b1, 16'h0002, 32'h12345678, 32'h00000000};
        vecs[12] = '{1'b0, 16'h0002, 32'h00000000, 32'h00002010};

        rst              = 1'b1;
        du_stall         = 1'b0;
        core_trap        = 1'b0;
        core_retire      = 1'b0;
        du_if.du_strobe  = 1'b0;
        du_if.du_write   = 1'b0;
        du_if.du_adr     = '0;
        du_if.du_data_in = '0;

        #22 rst = 1'b0;
        #1;
        chk("rst_du_ack", {31'b0, du_if.du_ack}, 32'h0);
        chk("rst_du_data_out", du_if.du_data_out, 32'h0);
        chk("rst_breakpoint", {31'b0, du_breakpoint}, 32'h0);
        chk("rst_core_stall", {31'b0, core_stall}, 32'h0);
        chk("rst_spr_req", {31'b0, spr_req}, 32'h0);
        chk("rst_spr_we", {31'b0, spr_we}, 32'h0);
        chk("rst_spr_addr", {17'b0, spr_addr}, 32'h0);

        // Local register map
        for (int i = 0; i < 13; i++) begin
            access(vecs[i].write, vecs[i].adr, vecs[i].wdata, vecs[i].exp, lat);
            chk("local_latency", lat, 2);
        end

        // SPR accesses while stalled by the debugger
        du_stall = 1'b1;
        spr_delay = 3; spr_data = 32'hA5A5A5A5;
        access(1'b0, 16'h1234, 32'h0, 32'hA5A5A5A5, lat);
        chk("spr_read_latency", lat, 4);
        chk("spr_read_addr", {17'b0, seen_addr}, 32'h00001234);
        chk("spr_read_we", {31'b0, seen_we}, 32'h0);

        spr_delay = 1; spr_data = 32'h11111111;
        access(1'b1, 16'h7FFF, 32'h12345678, 32'h00000000, lat);
        chk("spr_write_addr", {17'b0, seen_addr}, 32'h00007FFF);
        chk("spr_write_we", {31'b0, seen_we}, 32'h1);
        chk("spr_write_wdata", seen_wdata, 32'h12345678);

        spr_delay = 2; spr_data = 32'h0BADF00D;
        access(1'b0, 16'h9000, 32'h0, 32'h0BADF00D, lat);
        chk("spr_base_addr", {17'b0, seen_addr}, 32'h00001000);

        // Timeout, then a stray late ack
        spr_delay = 0;
        access(1'b0, 16'h2222, 32'h0, 32'hDEADBEEF, lat);
        chk("timeout_latency", lat, 65);
        chk("timeout_req_cycles", spr_cnt_last, 64);
        @(posedge clk); #1;
        spr_kick = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_no_req", {31'b0, spr_req}, 32'h0);
        chk("late_ack_no_du_ack", {31'b0, du_if.du_ack}, 32'h0);
        spr_delay = 2; spr_data = 32'h13572468;
        access(1'b0, 16'h3000, 32'h0, 32'h13572468, lat);

        // SPR access waits until the core is stalled
        du_stall = 1'b0;
        repeat (2) @(posedge clk);
        spr_delay = 2; spr_data = 32'h600DCAFE;
        start_access(1'b0, 16'h2000, 32'h0, 32'h600DCAFE);
        repeat (4) @(posedge clk);
        #1;
        chk("unstalled_no_req", {31'b0, spr_req}, 32'h0);
        chk("unstalled_no_ack", {31'b0, du_if.du_ack}, 32'h0);
        du_stall = 1'b1;
        finish_access(lat);
        du_stall = 1'b0;
        repeat (2) @(posedge clk);

        // Trap breakpoint and resume
        pulse(1'b1, 1'b0);
        chk("bp_core_stall", {31'b0, core_stall}, 32'h1);
        chk("bp_breakpoint", {31'b0, du_breakpoint}, 32'h1);
        access(1'b0, 16'h0001, 32'h0, 32'h00000001, lat);
        spr_delay = 2; spr_data = 32'h24681357;
        access(1'b0, 16'h4000, 32'h0, 32'h24681357, lat);
        @(posedge clk); #1 du_stall = 1'b1;
        @(posedge clk); #1 du_stall = 1'b0;
        @(posedge clk); #1;
        chk("resume_core_stall", {31'b0, core_stall}, 32'h0);
        chk("resume_breakpoint", {31'b0, du_breakpoint}, 32'h0);
        access(1'b1, 16'h0001, 32'h00000001, 32'h0, lat);
        access(1'b0, 16'h0001, 32'h0, 32'h00000000, lat);

        // Single step (STEP_EN left set by the table)
        pulse(1'b0, 1'b1);
        chk("step_core_stall", {31'b0, core_stall}, 32'h1);
        access(1'b0, 16'h0001, 32'h0, 32'h00000002, lat);
        access(1'b1, 16'h0001, 32'h00000002, 32'h0, lat);
        chk("step_clear_bp", {31'b0, du_breakpoint}, 32'h0);

        // Trap and retire together; a partial clear keeps the hold
        pulse(1'b1, 1'b1);
        access(1'b0, 16'h0001, 32'h0, 32'h00000003, lat);
        access(1'b1, 16'h0001, 32'h00000001, 32'h0, lat);
        chk("partial_clear_hold", {31'b0, du_breakpoint}, 32'h1);
        access(1'b0, 16'h0001, 32'h0, 32'h00000002, lat);
        access(1'b1, 16'h0001, 32'h00000002, 32'h0, lat);
        chk("full_clear_hold", {31'b0, du_breakpoint}, 32'h0);

        // Reset in the middle of an SPR access
        pulse(1'b1, 1'b0);
        du_stall = 1'b1;
        spr_delay = 0;
        start_access(1'b0, 16'h1500, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_spr_req", {31'b0, spr_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_spr_req", {31'b0, spr_req}, 32'h0);
        chk("mid_rst_du_ack", {31'b0, du_if.du_ack}, 32'h0);
        chk("mid_rst_breakpoint", {31'b0, du_breakpoint}, 32'h0);
        exp_q.delete();
        du_if.du_strobe = 1'b0;
        du_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        access(1'b0, 16'h0001, 32'h0, 32'h00000000, lat);
        chk("post_rst_latency", lat, 2);
        access(1'b0, 16'h0000, 32'h0, 32'h00000000, lat);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
